// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared encodings for the seven-segment display arbiter
package seg_disp_pkg;

    // Encodings double as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    localparam logic [15:0] BLANK_WORD = 16'hFFFF;

    localparam int DIGIT_W    = 4;
    localparam int DIGIT0_LSB = 0;
    localparam int DIGIT1_LSB = 4;
    localparam int DIGIT2_LSB = 8;
    localparam int DIGIT3_LSB = 12;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - saturating dwell counter with clear/enable and done flag
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LP_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == LP_LAST);

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin owner of the shared four-digit BCD display
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] bcd0,
    input  logic [15:0] bcd1,
    output logic [1:0]  gnt,
    output logic [15:0] bcd_out,
    output logic        dwell_done
);

    state_t r_state;
    state_t w_next;
    logic   r_last_owner;
    logic   w_owned;
    logic   w_enter;
    logic   w_timer_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1)  w_next = r_last_owner ? ST_OWN0 : ST_OWN1;
                else if (req0)     w_next = ST_OWN0;
                else if (req1)     w_next = ST_OWN1;
                else               w_next = ST_IDLE;
            end
            // Release beats dwell: an owner dropping its request leaves at once.
            ST_OWN0: begin
                if (!req0)                     w_next = req1 ? ST_OWN1 : ST_IDLE;
                else if (dwell_done && req1)   w_next = ST_OWN1;
                else                           w_next = ST_OWN0;
            end
            ST_OWN1: begin
                if (!req1)                     w_next = req0 ? ST_OWN0 : ST_IDLE;
                else if (dwell_done && req0)   w_next = ST_OWN0;
                else                           w_next = ST_OWN1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_owned    = (r_state != ST_IDLE);
    assign w_enter    = (w_next != ST_IDLE) && (w_next != r_state);
    assign dwell_done = w_owned && w_timer_done;

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (reset),
        .i_clear  (w_enter),
        .i_enable (w_owned),
        .o_done   (w_timer_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            gnt          <= 2'b00;
            bcd_out      <= BLANK_WORD;
        end else begin
            r_state <= w_next;
            gnt     <= w_next;
            if (w_enter) r_last_owner <= (w_next == ST_OWN1);
            // Digits follow the owner every cycle, not just at grant time.
            case (w_next)
                ST_OWN0: bcd_out <= bcd0;
                ST_OWN1: bcd_out <= bcd1;
                default: bcd_out <= BLANK_WORD;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - randomized and directed bench for seg_display_arbiter
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [15:0] bcd0, bcd1;
    logic [1:0]  gnt_a, gnt_b;
    logic [15:0] out_a, out_b;
    logic        done_a, done_b;

    int checks = 0;
    int fails  = 0;

    int m_owner [2];
    int m_age   [2];
    int m_last  [2];
    int m_dwell [2] = '{4, 1};

    always #5 clk = ~clk;

    seg_display_arbiter #(.DWELL_CYCLES(4), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .bcd0(bcd0), .bcd1(bcd1), .gnt(gnt_a), .bcd_out(out_a), .dwell_done(done_a)
    );

    seg_display_arbiter #(.DWELL_CYCLES(1), .CNT_W(1)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .bcd0(bcd0), .bcd1(bcd1), .gnt(gnt_b), .bcd_out(out_b), .dwell_done(done_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0;
            m_age[k]   = 0;
            m_last[k]  = 1;
        end
    endtask

    function automatic logic wants(input int who);
        return (who == 1) ? req0 : req1;
    endfunction

    // Owner 0 means nobody; 1 is requester 0, 2 is requester 1.
    task automatic model_step(input int k);
        int cur, nxt, oth;
        cur = m_owner[k];
        nxt = cur;
        if (cur == 0) begin
            if (req0 && req1)  nxt = (m_last[k] == 1) ? 1 : 2;
            else if (req0)     nxt = 1;
            else if (req1)     nxt = 2;
            else               nxt = 0;
        end else begin
            oth = 3 - cur;
            if (!wants(cur))                                   nxt = wants(oth) ? oth : 0;
            else if (m_age[k] >= m_dwell[k] - 1 && wants(oth)) nxt = oth;
        end
        if (nxt != 0 && nxt != cur) begin
            m_age[k]  = 0;
            m_last[k] = nxt - 1;
        end else if (nxt != 0) begin
            m_age[k] = m_age[k] + 1;
        end
        m_owner[k] = nxt;
    endtask

    task automatic check_all(input string phase);
        logic [1:0]  eg;
        logic [15:0] eb;
        logic        ed;
        for (int k = 0; k < 2; k++) begin
            eg = (m_owner[k] == 1) ? 2'b01 : (m_owner[k] == 2) ? 2'b10 : 2'b00;
            eb = (m_owner[k] == 1) ? bcd0 : (m_owner[k] == 2) ? bcd1 : 16'hFFFF;
            ed = (m_owner[k] != 0) && (m_age[k] >= m_dwell[k] - 1);
            if (k == 0) begin
                chk($sformatf("%s gnt_d4", phase),  16'(gnt_a),  16'(eg));
                chk($sformatf("%s bcd_d4", phase),  out_a,       eb);
                chk($sformatf("%s done_d4", phase), 16'(done_a), 16'(ed));
            end else begin
                chk($sformatf("%s gnt_d1", phase),  16'(gnt_b),  16'(eg));
                chk($sformatf("%s bcd_d1", phase),  out_b,       eb);
                chk($sformatf("%s done_d1", phase), 16'(done_b), 16'(ed));
            end
        end
    endtask

    // Inputs are held stable across the edge and compared 1 time unit after it.
    task automatic cycle(input logic r0, input logic r1,
                         input logic [15:0] b0, input logic [15:0] b1, input string phase);
        req0 = r0; req1 = r1; bcd0 = b0; bcd1 = b1;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1 check_all(phase);
    endtask

    task automatic async_reset(input string phase);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all(phase);
        @(posedge clk);
        #1 check_all({phase, "_held"});
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; bcd0 = '0; bcd1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        reset = 1'b1;
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "idle");

        cycle(1'b1, 1'b0, 16'h1234, 16'hAAAA, "single_grant");
        cycle(1'b1, 1'b0, 16'h5678, 16'hAAAA, "single_live");
        cycle(1'b0, 1'b0, 16'h5678, 16'hAAAA, "single_drop");

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1111, 16'h9876, "own1");
        async_reset("reset_mid_own1");

        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b1, 16'($urandom), 16'($urandom), "tie");

        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "pre_early");
        cycle(1'b1, 1'b0, 16'h2222, 16'h3333, "early_own0");
        cycle(1'b1, 1'b1, 16'h2222, 16'h3333, "early_contend");
        cycle(1'b0, 1'b1, 16'h2222, 16'h3333, "early_release");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h2222, 16'h3333, "early_after");

        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "pre_sat");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 16'h4444, 16'h0420, "saturate");
        cycle(1'b1, 1'b1, 16'h4444, 16'h0420, "sat_preempt");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset("rand_reset");
            end else begin
                cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      16'($urandom), 16'($urandom), "random");
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's single four-digit multiplexed seven-segment display between two independent requesters, such as a stopwatch and an event counter. A two-state-plus-idle round-robin FSM grants the display, enforces a minimum dwell time against preemption, and drives the registered 16-bit BCD word consumed by the display scanner. With no owner, the block drives an all-blank code.

## Interface
- DWELL_CYCLES, 50_000_000: minimum contested ownership time in clk cycles; must be ≥ 1.
- CNT_W, 26: dwell counter width; must satisfy 2^CNT_W ≥ DWELL_CYCLES.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- req0  input  1  requester 0 wants the display; level, held while it wants ownership.
- req1  input  1  requester 1 wants the display; level.
- bcd0  input  16  requester 0 digits [15:12][11:8][7:4][3:0].
- bcd1  input  16  requester 1 digits, same packing.
- gnt  output  2  one-hot grant: gnt[0] for requester 0, gnt[1] for requester 1; 00 when idle.
- bcd_out  output  16  word to the display scanner.
- dwell_done  output  1  high while the current owner's dwell has expired.

## Operation
- States: IDLE, OWN0, OWN1. A `last_owner` bit records the most recent grantee.
- **IDLE:**
  - Only req0 → OWN0.
  - Only req1 → OWN1.
  - Both asserted → grant the requester ≠ last_owner.
  - Neither asserted → stay in IDLE.
- **OWNx, owner drops reqx:** release immediately, regardless of dwell.
  - If the other requester is asserting → go directly to OWN(other), with no IDLE cycle.
  - Otherwise → IDLE.
- **OWNx, reqx held, dwell_done=1, other requester asserting:** switch to OWN(other). This is round-robin preemption.
- **OWNx, reqx held, otherwise:** stay.
- **last_owner:** updated on every entry into OWNx.
- **Dwell counter:**
  - Cleared to 0 on every entry into OWN0/OWN1, including direct switches.
  - Increments each owned cycle while count < DWELL_CYCLES-1, then saturates.
  - dwell_done = owned state && count == DWELL_CYCLES-1.
- **bcd_out:** registered from the next-state selection each edge.
  - Next state OWN0 → bcd0.
  - Next state OWN1 → bcd1.
  - Next state IDLE → 16'hFFFF (blank; the scanner decodes non-BCD nibbles as all segments off).
- **Live digits:** while owned, digit changes on the owner's bcd propagate every cycle, not only at grant.
- **gnt:** registered; always matches the current state. Never 11.

## Timing
- **Reset values:** state IDLE, gnt=00, bcd_out=16'hFFFF, dwell_done=0, count=0, last_owner=1. Requester 0 therefore wins the first tie.
- **Grant latency:** 1 cycle. req sampled high at edge E → gnt and bcd_out valid after E.
- **Data latency:** 1 cycle. A bcd change on the owner's input at edge E appears on bcd_out after E.
- **Minimum contested ownership:** exactly DWELL_CYCLES cycles. The switch occurs on the edge ending the first cycle with dwell_done=1.
- **DWELL_CYCLES=1:** dwell_done is high in the first owned cycle, so contested ownership alternates every cycle.
- **Simultaneous owner release and dwell expiry:** release rule applies; same result when the other requester is pending.
- **Reset mid-ownership:** immediate asynchronous return to reset values. The grant is not retained.
- **Requester glitches:** no qualification. A single-cycle req pulse yields a single-cycle grant.

## Structure
- Shared package `seg_disp_pkg`:
  - State encodings IDLE/OWN0/OWN1.
  - BLANK_WORD = 16'hFFFF.
  - BCD digit field offsets, shared with the display scanner.
- One natural sub-module, `dwell_timer`: saturating counter with clear and enable inputs and a done output, parameterised by DWELL_CYCLES and CNT_W.
- FSM, last_owner, and output registers live in the top.

## Test plan
All scenarios use DWELL_CYCLES=4.
- **Reset:** release reset with req0=req1=0 → gnt=00, bcd_out=FFFF. Assert reset mid-OWN1 → next observable values gnt=00, bcd_out=FFFF, asynchronously.
- **Single requester:** req0=1, bcd0=16'h1234 at edge E → gnt=01, bcd_out=1234 after E. Change bcd0 to 5678 → bcd_out=5678 one cycle later. Drop req0 → gnt=00, bcd_out=FFFF next cycle.
- **Tie from reset:** req0=req1=1 together → OWN0 for exactly 4 cycles, then OWN1 for 4, then OWN0, alternating. bcd_out tracks the owner, and gnt is never 11.
- **Early release with pending requester:** OWN0 in cycle 2 of dwell, req1=1; drop req0 → gnt=10 on the next edge with no IDLE cycle, and the dwell count restarts at 0.
- **Uncontested saturation:** req1 held alone for 20 cycles → gnt stays 10, dwell_done=1 from cycle 4 onward. Assert req0 → switch to OWN0 on the next edge.
- **DWELL_CYCLES=1 variant:** both requesters asserting → gnt alternates 01/10 every cycle.
